// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Holds the FSM state encoding and the step-counter width rule.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_WIDTH_DEFAULT = 8;
    localparam int DIV_CNT_W         = cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring step: shift {rem,q} left, trial-subtract divisor, set quotient bit.
// Purely combinational; the remainder stays below the divisor, so rem<<1|bit fits in W+1 bits.
module divider_step #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] q_o
);

    logic [DATA_WIDTH:0] rem_sh;
    logic [DATA_WIDTH:0] trial;
    logic                fits;

    assign rem_sh = {rem_i, q_i[DATA_WIDTH-1]};
    assign trial  = rem_sh - {1'b0, divisor_i};
    assign fits   = (rem_sh >= {1'b0, divisor_i});

    // A successful trial leaves a result below the divisor, so the top bit is always zero.
    assign rem_o = DATA_WIDTH'(fits ? trial : rem_sh);
    assign q_o   = {q_i[DATA_WIDTH-2:0], fits};

endmodule

// File: rtl/divider_8bit.sv
// Sequential unsigned divider, one quotient bit per clock, valid/ready on both sides.
// The first step is folded into the accept edge so the result appears DATA_WIDTH edges later.
module divider_8bit
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand_dividend,
    input  logic [DATA_WIDTH-1:0] operand_divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient_out,
    output logic [DATA_WIDTH-1:0] remainder_out,
    output logic                  div_by_zero
);

    localparam int              CNT_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    div_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic                  dbz_q, dbz_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] step_rem_in, step_q_in, step_dvs_in;
    logic [DATA_WIDTH-1:0] step_rem_out, step_q_out;

    assign accept = in_valid && (state_q == IDLE);

    // On accept the step runs on the raw operands; afterwards on the registered state.
    assign step_rem_in = accept ? '0               : rem_q;
    assign step_q_in   = accept ? operand_dividend : quo_q;
    assign step_dvs_in = accept ? operand_divisor  : dvs_q;

    divider_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem_i     (step_rem_in),
        .q_i       (step_q_in),
        .divisor_i (step_dvs_in),
        .rem_o     (step_rem_out),
        .q_o       (step_q_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = operand_divisor;
                    if (operand_divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = operand_dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        quo_d   = step_q_out;
                        rem_d   = step_rem_out;
                        cnt_d   = CNT_W'(1);
                        dbz_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                quo_d = step_q_out;
                rem_d = step_rem_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign quotient_out  = quo_q;
    assign remainder_out = rem_q;
    assign div_by_zero   = dbz_q;

endmodule
